// File: rtl/jk_bank_sequencer.sv
// Command sequencer for a bank of JK flip-flops: turns SET/CLEAR/TOGGLE/LOAD/COUNT
// commands into one-cycle J/K pulses, waits a settle window, then returns the sampled Q.
module jk_bank_sequencer #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] q_in,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             busy
);

  localparam int SCNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [2:0] OP_SET    = 3'd1;
  localparam logic [2:0] OP_CLEAR  = 3'd2;
  localparam logic [2:0] OP_TOGGLE = 3'd3;
  localparam logic [2:0] OP_LOAD   = 3'd4;
  localparam logic [2:0] OP_COUNT  = 3'd5;

  typedef enum logic [1:0] {IDLE, APPLY, HOLD, RESP} state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [SCNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]    j_q, j_d, k_q, k_d;

  // Bits that flip when q is incremented: trailing ones plus the next zero.
  function automatic logic [WIDTH-1:0] inc_mask(input logic [WIDTH-1:0] q);
    return q ^ (q + WIDTH'(1));
  endfunction

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    j_d     = '0;
    k_d     = '0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          rem_d   = cmd_data[CNT_W-1:0];
          cnt_d   = '0;
          state_d = RESP;
          case (cmd_op)
            OP_SET: begin
              state_d = APPLY;
              j_d     = cmd_mask;
            end
            OP_CLEAR: begin
              state_d = APPLY;
              k_d     = cmd_mask;
            end
            OP_TOGGLE: begin
              state_d = APPLY;
              j_d     = cmd_mask;
              k_d     = cmd_mask;
            end
            OP_LOAD: begin
              state_d = APPLY;
              j_d     = cmd_mask & cmd_data;
              k_d     = cmd_mask & ~cmd_data;
            end
            OP_COUNT: begin
              if (cmd_data[CNT_W-1:0] != '0) begin
                state_d = APPLY;
                j_d     = inc_mask(q_in);
                k_d     = inc_mask(q_in);
              end
            end
            default: ;
          endcase
        end
      end
      APPLY: begin
        state_d = HOLD;
        cnt_d   = '0;
      end
      HOLD: begin
        if (cnt_q == SCNT_W'(SETTLE - 1)) begin
          // Q has settled here, so the next COUNT step is derived from it directly.
          if (op_q == OP_COUNT && rem_q > CNT_W'(1)) begin
            rem_d   = rem_q - CNT_W'(1);
            state_d = APPLY;
            j_d     = inc_mask(q_in);
            k_d     = inc_mask(q_in);
          end else begin
            state_d = RESP;
          end
        end else begin
          cnt_d = cnt_q + SCNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
      j_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      j_q     <= j_d;
      k_q     <= k_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q <= op_d;
  end

  assign J         = j_q;
  assign K         = k_q;
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = (state_q == RESP) ? q_in : '0;
  assign rsp_err   = (state_q == RESP) && (op_q[2:1] == 2'b11);

endmodule
